// File: rtl/mult_seq_ctrl.sv
// Sequential W x W unsigned multiplier: one 2x2 cell swept over every radix-4 digit pair.
// Optional MULT_SEQ_ZERO_SKIP_EN: a zero operand bypasses RUN and completes in one cycle.

module multiplier_2x2 (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic [3:0] p
);
   assign p = {2'b00, a} * {2'b00, b};
endmodule

module mult_seq_ctrl #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] p
);
   localparam int D  = W / 2;
   localparam int CW = (D > 1) ? $clog2(D) : 1;
   localparam logic [CW-1:0] LAST = CW'(D - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t         state_q;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [CW-1:0]  i_q;
   logic [CW-1:0]  j_q;
   logic [2*W-1:0] acc_q;
   logic [2*W-1:0] p_q;
   logic           busy_q;
   logic           done_q;

   logic [1:0]     a_dig [D];
   logic [1:0]     b_dig [D];
   logic [3:0]     pp;
   logic [CW:0]    dig_sum;
   logic [CW+1:0]  shamt;
   logic [2*W-1:0] acc_d;

   for (genvar gi = 0; gi < D; gi++) begin : g_digit
      assign a_dig[gi] = a_q[2*gi +: 2];
      assign b_dig[gi] = b_q[2*gi +: 2];
   end

   multiplier_2x2 u_cell (
      .a (a_dig[i_q]),
      .b (b_dig[j_q]),
      .p (pp)
   );

   // Digit pair (i, j) carries weight 4^(i+j), i.e. a left shift of 2(i+j).
   assign dig_sum = {1'b0, i_q} + {1'b0, j_q};
   assign shamt   = {dig_sum, 1'b0};
   assign acc_d   = acc_q + ((2*W)'(pp) << shamt);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         acc_q   <= '0;
         p_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q    <= a;
                  b_q    <= b;
                  acc_q  <= '0;
                  i_q    <= '0;
                  j_q    <= '0;
                  busy_q <= 1'b1;
`ifdef MULT_SEQ_ZERO_SKIP_EN
                  if (a == '0 || b == '0) begin
                     state_q <= S_DONE;
                     p_q     <= '0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_RUN;
                  end
`else
                  state_q <= S_RUN;
`endif
               end
            end
            S_RUN: begin
               acc_q <= acc_d;
               if (i_q == LAST) begin
                  i_q <= '0;
                  if (j_q == LAST) begin
                     j_q     <= '0;
                     p_q     <= acc_d;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     j_q <= j_q + 1'b1;
                  end
               end else begin
                  i_q <= i_q + 1'b1;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign p    = p_q;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: a W=8 instance for handshake/timing scenarios and a W=2 instance swept exhaustively.

module tb_mult_seq_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic        start8, start2;
   logic [7:0]  a8, b8;
   logic [1:0]  a2, b2;
   logic        busy8, done8, busy2, done2;
   logic [15:0] p8;
   logic [3:0]  p2;

   logic [15:0] sb8[$];
   logic [3:0]  sb2[$];
   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mult_seq_ctrl #(.W(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .p(p8)
   );

   mult_seq_ctrl #(.W(2)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .p(p2)
   );

   // Called at the negedge just after the start edge; follows the op to DONE and back to IDLE.
   task automatic wait_done8(input int exp_lat, input logic chk_hold,
                             input logic [15:0] hold_val, input logic hold_start);
      int k = 0;
      logic [15:0] exp_p;
      vectors++;
      if (busy8 !== 1'b1) begin
         miscompares++;
         $display("FAIL busy_after_start: busy=%b required 1", busy8);
      end
      while (done8 !== 1'b1 && k < 200) begin
         if (chk_hold) begin
            vectors++;
            if (p8 !== hold_val) begin
               miscompares++;
               $display("FAIL p_hold cycle %0d: p=%0d required %0d", k, p8, hold_val);
            end
         end
         if (hold_start) begin
            start8 = 1'b1; a8 = 8'd200; b8 = 8'd200;
         end
         @(negedge clk);
         k++;
      end
      start8 = 1'b0;
      vectors++;
      if (done8 !== 1'b1) begin
         miscompares++;
         $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done8, k);
      end else if (k != exp_lat) begin
         miscompares++;
         $display("FAIL latency: done after %0d edges, required %0d", k, exp_lat);
      end
      vectors++;
      if (sb8.size() == 0) begin
         miscompares++;
         $display("FAIL scoreboard_empty: p=%0d with nothing expected", p8);
      end else begin
         exp_p = sb8.pop_front();
         if (p8 !== exp_p) begin
            miscompares++;
            $display("FAIL product: p=%0d required %0d", p8, exp_p);
         end
      end
      @(negedge clk);
      vectors++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
         miscompares++;
         $display("FAIL back_to_idle: done=%b busy=%b required 0 0", done8, busy8);
      end
   endtask

   task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic push);
      start8 = 1'b1; a8 = av; b8 = bv;
      if (push) sb8.push_back(16'(int'(av) * int'(bv)));
      @(negedge clk);
      start8 = 1'b0;
   endtask

   function automatic int lat8(input logic [7:0] av, input logic [7:0] bv);
`ifdef MULT_SEQ_ZERO_SKIP_EN
      if (av == 8'd0 || bv == 8'd0) return 0;
`endif
      return 16;
   endfunction

   task automatic test_reset();
      reset = 1'b1; start8 = 1'b0; start2 = 1'b0;
      a8 = '0; b8 = '0; a2 = '0; b2 = '0;
      repeat (2) @(negedge clk);
      vectors++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'd0) begin
         miscompares++;
         $display("FAIL reset8: busy=%b done=%b p=%0d required 0 0 0", busy8, done8, p8);
      end
      vectors++;
      if (busy2 !== 1'b0 || done2 !== 1'b0 || p2 !== 4'd0) begin
         miscompares++;
         $display("FAIL reset2: busy=%b done=%b p=%0d required 0 0 0", busy2, done2, p2);
      end
      reset = 1'b0;
      @(negedge clk);
      $display("reset: checked idle outputs");
   endtask

   task automatic test_max();
      issue8(8'd255, 8'd255, 1'b1);
      wait_done8(16, 1'b0, 16'd0, 1'b0);
      $display("max: 255*255 expected 65025, p=%0d", p8);
   endtask

   task automatic test_random();
      for (int n = 0; n < 4; n++) begin
         logic [7:0] av, bv;
         av = 8'($urandom_range(1, 255));
         bv = 8'($urandom_range(1, 255));
         @(negedge clk);
         issue8(av, bv, 1'b1);
         wait_done8(16, 1'b0, 16'd0, 1'b0);
         $display("random: %0d*%0d p=%0d", av, bv, p8);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      issue8(8'd13, 8'd11, 1'b1);
      wait_done8(16, 1'b0, 16'd0, 1'b0);
      // Now in the first IDLE cycle after DONE: start again right here.
      issue8(8'd7, 8'd9, 1'b1);
      wait_done8(16, 1'b1, 16'd143, 1'b0);
      $display("back_to_back: 13*11 then 7*9, final p=%0d", p8);
   endtask

   task automatic test_ignore_start();
      @(negedge clk);
      start8 = 1'b1; a8 = 8'd6; b8 = 8'd5; sb8.push_back(16'd30);
      @(negedge clk);
      wait_done8(16, 1'b1, 16'd63, 1'b1);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         vectors++;
         if (done8 !== 1'b0) begin
            miscompares++;
            $display("FAIL extra_done: done=%b at idle cycle %0d required 0", done8, n);
         end
      end
      $display("ignore_start: 6*5 with start held, p=%0d", p8);
   endtask

   task automatic test_reset_abort();
      @(negedge clk);
      issue8(8'd9, 8'd9, 1'b0);
      repeat (6) @(negedge clk);
      reset = 1'b1;
      #1;
      vectors++;
      if (p8 !== 16'd0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: p=%0d busy=%b done=%b required 0 0 0", p8, busy8, done8);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         vectors++;
         if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            miscompares++;
            $display("FAIL aborted_op: done=%b busy=%b required 0 0", done8, busy8);
         end
      end
      issue8(8'd3, 8'd4, 1'b1);
      wait_done8(16, 1'b0, 16'd0, 1'b0);
      $display("reset_abort: aborted 9*9, then 3*4 p=%0d", p8);
   endtask

   task automatic test_zero();
      @(negedge clk);
      issue8(8'd0, 8'd77, 1'b1);
      wait_done8(lat8(8'd0, 8'd77), 1'b1, 16'd12, 1'b0);
      $display("zero: 0*77 p=%0d", p8);
   endtask

   task automatic test_w2_exhaustive();
      for (int x = 0; x < 4; x++) begin
         for (int y = 0; y < 4; y++) begin
            int k = 0;
            int exp_lat = 1;
            logic [3:0] exp_p;
`ifdef MULT_SEQ_ZERO_SKIP_EN
            if (x == 0 || y == 0) exp_lat = 0;
`endif
            @(negedge clk);
            start2 = 1'b1; a2 = 2'(x); b2 = 2'(y);
            sb2.push_back(4'(x * y));
            @(negedge clk);
            start2 = 1'b0;
            while (done2 !== 1'b1 && k < 20) begin
               @(negedge clk);
               k++;
            end
            vectors++;
            if (done2 !== 1'b1 || k != exp_lat) begin
               miscompares++;
               $display("FAIL w2_latency %0d*%0d: done=%b after %0d edges, required 1 after %0d", x, y, done2, k, exp_lat);
            end
            exp_p = sb2.pop_front();
            vectors++;
            if (p2 !== exp_p) begin
               miscompares++;
               $display("FAIL w2_product %0d*%0d: p=%0d required %0d", x, y, p2, exp_p);
            end
            @(negedge clk);
            vectors++;
            if (done2 !== 1'b0 || busy2 !== 1'b0) begin
               miscompares++;
               $display("FAIL w2_idle: done=%b busy=%b required 0 0", done2, busy2);
            end
            $display("w2: %0d*%0d p=%0d", x, y, p2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_max();
      test_random();
      test_back_to_back();
      test_ignore_start();
      test_reset_abort();
      test_zero();
      test_w2_exhaustive();
      vectors++;
      if (sb8.size() != 0 || sb2.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_leftover: %0d/%0d entries required 0/0", sb8.size(), sb2.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
